// File: rtl/agex_pkg.sv
// Shared types for the AGEX stage: opcode enum, latch layouts and FSM states.
// Every pipeline latch is a packed struct, so it also serves as a flat bus.
package agex_pkg;

  localparam int DBITS        = 32;
  localparam int MUL_STEP_DEF = 2;

  typedef enum logic [5:0] {
    INVALID_I = 6'd0,
    ADD_I, SUB_I, AND_I, OR_I, XOR_I, SLT_I, SLTU_I, SLL_I, SRL_I, SRA_I,
    ADDI_I, ANDI_I, ORI_I, XORI_I, SLTI_I, SLTIU_I, SLLI_I, SRLI_I, SRAI_I,
    LUI_I, AUIPC_I, LW_I, SW_I,
    JAL_I, JALR_I, BEQ_I, BNE_I, BLT_I, BGE_I, BLTU_I, BGEU_I,
    MUL_I
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } agex_state_e;

  typedef struct packed {
    logic [31:0]      inst;
    logic [DBITS-1:0] PC;
    logic [DBITS-1:0] pcplus;
    op_e              op_I;
    logic [31:0]      inst_count;
    logic [DBITS-1:0] rs1_val;
    logic [DBITS-1:0] rs2_val;
    logic [4:0]       rd;
    logic [DBITS-1:0] sxt_imm;
    logic             wr_reg;
    logic [31:0]      bus_canary;
  } de_latch_t;

  typedef struct packed {
    logic [31:0]      inst;
    logic [DBITS-1:0] PC;
    op_e              op_I;
    logic [31:0]      inst_count;
    logic [DBITS-1:0] result;
    logic [DBITS-1:0] st_data;
    logic [4:0]       rd;
    logic             wr_reg;
    logic [31:0]      bus_canary;
  } agex_latch_t;

  typedef struct packed {
    logic       agex_stall;
    logic [4:0] agex_rd;
    logic       agex_wr;
  } to_de_t;

  typedef struct packed {
    logic             br_redirect;
    logic [DBITS-1:0] br_target;
  } to_fe_t;

  localparam int DE_LATCH_WIDTH        = $bits(de_latch_t);
  localparam int AGEX_LATCH_WIDTH      = $bits(agex_latch_t);
  localparam int FROM_AGEX_TO_DE_WIDTH = $bits(to_de_t);
  localparam int FROM_AGEX_TO_FE_WIDTH = $bits(to_fe_t);

  function automatic logic is_ctrl(input op_e op);
    return op inside {JAL_I, JALR_I, BEQ_I, BNE_I, BLT_I, BGE_I, BLTU_I, BGEU_I};
  endfunction

  function automatic agex_latch_t make_entry(input de_latch_t d,
                                             input logic [DBITS-1:0] result,
                                             input logic [DBITS-1:0] st_data);
    agex_latch_t e;
    e.inst       = d.inst;
    e.PC         = d.PC;
    e.op_I       = d.op_I;
    e.inst_count = d.inst_count;
    e.result     = result;
    e.st_data    = st_data;
    e.rd         = d.rd;
    e.wr_reg     = d.wr_reg;
    e.bus_canary = d.bus_canary;
    return e;
  endfunction

endpackage

// File: rtl/agex_stage_mul_iter.sv
// Iterative shift-add multiplier retiring MUL_STEP multiplier bits per cycle.
// done/product are combinational in the final busy cycle so the caller can latch them.
module agex_mul_iter #(
  parameter int DBITS    = 32,
  parameter int MUL_STEP = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [DBITS-1:0] a_i,
  input  logic [DBITS-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [DBITS-1:0] product_o
);

  localparam int N  = DBITS / MUL_STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic             busy_q;
  logic [CW-1:0]    count_q;
  logic [DBITS-1:0] acc_q, mcand_q, mplier_q;
  logic [DBITS-1:0] partial, acc_d;

  always_comb begin
    partial = '0;
    for (int i = 0; i < MUL_STEP; i++) begin
      if (mplier_q[i]) partial = partial + (mcand_q << i);
    end
    acc_d = acc_q + partial;
  end

  assign busy_o    = busy_q;
  assign done_o    = busy_q && (count_q == CW'(N - 1));
  assign product_o = acc_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q   <= 1'b0;
      count_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (!busy_q) begin
      if (start_i) begin
        busy_q   <= 1'b1;
        count_q  <= '0;
        acc_q    <= '0;
        mcand_q  <= a_i;
        mplier_q <= b_i;
      end
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << MUL_STEP;
      mplier_q <= mplier_q >> MUL_STEP;
      count_q  <= count_q + CW'(1);
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/agex_stage.sv
// AGEX stage: ALU, address generation, branch resolution and a multi-cycle MUL.
// Redirect and hazard outputs are combinational; the AGEX latch is registered.
module agex_stage
  import agex_pkg::*;
#(
  parameter int MUL_STEP = MUL_STEP_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  de_latch_t   from_DE_latch,
  output to_de_t      from_AGEX_to_DE,
  output to_fe_t      from_AGEX_to_FE,
  output agex_latch_t AGEX_latch_out
);

  de_latch_t        de;
  logic             in_valid;
  agex_state_e      state_q;
  agex_latch_t      latch_q, latch_d, mul_meta_q, mul_entry;
  logic [DBITS-1:0] rs1, rs2, imm;
  logic [DBITS-1:0] alu_res, st_data, pc_imm, rs1_imm;
  logic             br_taken;
  logic             mul_start, mul_busy, mul_done;
  logic [DBITS-1:0] mul_product;

  assign de       = from_DE_latch;
  assign in_valid = (de.op_I != INVALID_I);
  assign rs1      = de.rs1_val;
  assign rs2      = de.rs2_val;
  assign imm      = de.sxt_imm;
  assign pc_imm   = de.PC + imm;
  assign rs1_imm  = rs1 + imm;

  always_comb begin
    alu_res = '0;
    st_data = '0;
    unique case (de.op_I)
      ADD_I:   alu_res = rs1 + rs2;
      SUB_I:   alu_res = rs1 - rs2;
      AND_I:   alu_res = rs1 & rs2;
      OR_I:    alu_res = rs1 | rs2;
      XOR_I:   alu_res = rs1 ^ rs2;
      SLT_I:   alu_res = {{(DBITS-1){1'b0}}, $signed(rs1) < $signed(rs2)};
      SLTU_I:  alu_res = {{(DBITS-1){1'b0}}, rs1 < rs2};
      SLL_I:   alu_res = rs1 << rs2[4:0];
      SRL_I:   alu_res = rs1 >> rs2[4:0];
      SRA_I:   alu_res = $signed(rs1) >>> rs2[4:0];
      ADDI_I:  alu_res = rs1_imm;
      ANDI_I:  alu_res = rs1 & imm;
      ORI_I:   alu_res = rs1 | imm;
      XORI_I:  alu_res = rs1 ^ imm;
      SLTI_I:  alu_res = {{(DBITS-1){1'b0}}, $signed(rs1) < $signed(imm)};
      SLTIU_I: alu_res = {{(DBITS-1){1'b0}}, rs1 < imm};
      SLLI_I:  alu_res = rs1 << imm[4:0];
      SRLI_I:  alu_res = rs1 >> imm[4:0];
      SRAI_I:  alu_res = $signed(rs1) >>> imm[4:0];
      LUI_I:   alu_res = imm;
      AUIPC_I: alu_res = pc_imm;
      LW_I:    alu_res = rs1_imm;
      SW_I: begin
        alu_res = rs1_imm;
        st_data = rs2;
      end
      JAL_I, JALR_I: alu_res = de.pcplus;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    unique case (de.op_I)
      BEQ_I:   br_taken = (rs1 == rs2);
      BNE_I:   br_taken = (rs1 != rs2);
      BLT_I:   br_taken = ($signed(rs1) < $signed(rs2));
      BGE_I:   br_taken = ($signed(rs1) >= $signed(rs2));
      BLTU_I:  br_taken = (rs1 < rs2);
      BGEU_I:  br_taken = (rs1 >= rs2);
      default: br_taken = 1'b0;
    endcase
  end

  // Decode holds fetch on every control op, so we redirect even when not taken.
  always_comb begin
    from_AGEX_to_FE = '0;
    if (!reset && state_q == IDLE && in_valid && is_ctrl(de.op_I)) begin
      from_AGEX_to_FE.br_redirect = 1'b1;
      unique case (de.op_I)
        JAL_I:   from_AGEX_to_FE.br_target = pc_imm;
        JALR_I:  from_AGEX_to_FE.br_target = rs1_imm & {{(DBITS-1){1'b1}}, 1'b0};
        default: from_AGEX_to_FE.br_target = br_taken ? pc_imm : de.pcplus;
      endcase
    end
  end

  always_comb begin
    from_AGEX_to_DE = '0;
    if (!reset) begin
      if (state_q == BUSY) begin
        from_AGEX_to_DE.agex_stall = mul_busy;
        from_AGEX_to_DE.agex_rd    = mul_meta_q.rd;
        from_AGEX_to_DE.agex_wr    = mul_meta_q.wr_reg;
      end else if (in_valid) begin
        from_AGEX_to_DE.agex_stall = (de.op_I == MUL_I);
        from_AGEX_to_DE.agex_rd    = de.rd;
        from_AGEX_to_DE.agex_wr    = de.wr_reg;
      end
    end
  end

  assign mul_start = (state_q == IDLE) && (de.op_I == MUL_I);
  assign latch_d   = in_valid ? make_entry(de, alu_res, st_data) : '0;

  always_comb begin
    mul_entry        = mul_meta_q;
    mul_entry.result = mul_product;
  end

  agex_mul_iter #(
    .DBITS    (DBITS),
    .MUL_STEP (MUL_STEP)
  ) u_mul (
    .clk       (clk),
    .reset     (reset),
    .start_i   (mul_start),
    .a_i       (rs1),
    .b_i       (rs2),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  // A MUL parks its metadata here and emits bubbles until the multiplier finishes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      latch_q    <= '0;
      mul_meta_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (mul_start) begin
            state_q    <= BUSY;
            mul_meta_q <= make_entry(de, '0, '0);
            latch_q    <= '0;
          end else begin
            latch_q <= latch_d;
          end
        end
        BUSY: begin
          if (mul_done) begin
            state_q <= IDLE;
            latch_q <= mul_entry;
          end else begin
            latch_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          latch_q <= '0;
        end
      endcase
    end
  end

  assign AGEX_latch_out = latch_q;

endmodule

// File: tb/tb_agex_stage.sv
// Self-checking bench for agex_stage: directed plan cases plus randomized ops
// compared against a behavioural model built from the ISA rules.
module tb_agex_stage;
  import agex_pkg::*;

  localparam int N = DBITS / MUL_STEP_DEF;

  logic        clk = 1'b0;
  logic        reset;
  de_latch_t   din;
  to_de_t      to_de;
  to_fe_t      to_fe;
  agex_latch_t lat;

  int tests = 0;
  int fails = 0;

  to_de_t      obs_de;
  to_fe_t      obs_fe;
  agex_latch_t obs_latch;

  agex_stage #(.MUL_STEP(MUL_STEP_DEF)) dut (
    .clk             (clk),
    .reset           (reset),
    .from_DE_latch   (din),
    .from_AGEX_to_DE (to_de),
    .from_AGEX_to_FE (to_fe),
    .AGEX_latch_out  (lat)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  function automatic de_latch_t mk(input op_e op, input logic [31:0] pc,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] imm, input logic [4:0] rd,
                                   input logic wr);
    de_latch_t d;
    d.inst       = $urandom;
    d.PC         = pc;
    d.pcplus     = pc + 32'd4;
    d.op_I       = op;
    d.inst_count = $urandom;
    d.rs1_val    = a;
    d.rs2_val    = b;
    d.rd         = rd;
    d.sxt_imm    = imm;
    d.wr_reg     = wr;
    d.bus_canary = $urandom;
    return d;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // Reference: what the MEM stage should see for an instruction, from the ISA rules.
  function automatic agex_latch_t ref_latch(input de_latch_t d);
    agex_latch_t e;
    longint sa, sb, si;
    logic [31:0] a, b, i, r, s;
    a = d.rs1_val; b = d.rs2_val; i = d.sxt_imm;
    sa = longint'($signed(a)); sb = longint'($signed(b)); si = longint'($signed(i));
    r = 0; s = 0;
    case (d.op_I)
      ADD_I:   r = a + b;
      SUB_I:   r = a - b;
      AND_I:   r = a & b;
      OR_I:    r = a | b;
      XOR_I:   r = a ^ b;
      SLT_I:   r = (sa < sb) ? 1 : 0;
      SLTU_I:  r = (longint'(a) < longint'(b)) ? 1 : 0;
      SLL_I:   r = 32'(longint'(a) * (64'd1 << (b % 32)));
      SRL_I:   r = 32'(longint'(a) / (64'd1 << (b % 32)));
      SRA_I:   r = 32'(sa >>> (b % 32));
      ADDI_I:  r = 32'(sa + si);
      ANDI_I:  r = a & i;
      ORI_I:   r = a | i;
      XORI_I:  r = a ^ i;
      SLTI_I:  r = (sa < si) ? 1 : 0;
      SLTIU_I: r = (longint'(a) < longint'(i)) ? 1 : 0;
      SLLI_I:  r = 32'(longint'(a) * (64'd1 << (i % 32)));
      SRLI_I:  r = 32'(longint'(a) / (64'd1 << (i % 32)));
      SRAI_I:  r = 32'(sa >>> (i % 32));
      LUI_I:   r = i;
      AUIPC_I: r = d.PC + i;
      LW_I:    r = a + i;
      SW_I:    begin r = a + i; s = b; end
      JAL_I, JALR_I: r = d.pcplus;
      MUL_I:   r = 32'(longint'(a) * longint'(b));
      default: r = 0;
    endcase
    if (d.op_I == INVALID_I) return '0;
    e.inst = d.inst; e.PC = d.PC; e.op_I = d.op_I; e.inst_count = d.inst_count;
    e.result = r; e.st_data = s; e.rd = d.rd; e.wr_reg = d.wr_reg;
    e.bus_canary = d.bus_canary;
    return e;
  endfunction

  function automatic to_fe_t ref_fe(input de_latch_t d);
    to_fe_t f;
    bit taken;
    longint sa, sb;
    sa = longint'($signed(d.rs1_val)); sb = longint'($signed(d.rs2_val));
    f = '0;
    taken = 0;
    case (d.op_I)
      BEQ_I:  taken = (d.rs1_val == d.rs2_val);
      BNE_I:  taken = (d.rs1_val != d.rs2_val);
      BLT_I:  taken = (sa < sb);
      BGE_I:  taken = (sa >= sb);
      BLTU_I: taken = (longint'(d.rs1_val) < longint'(d.rs2_val));
      BGEU_I: taken = (longint'(d.rs1_val) >= longint'(d.rs2_val));
      default: taken = 0;
    endcase
    case (d.op_I)
      JAL_I:  begin f.br_redirect = 1; f.br_target = d.PC + d.sxt_imm; end
      JALR_I: begin f.br_redirect = 1; f.br_target = (d.rs1_val + d.sxt_imm) & 32'hFFFF_FFFE; end
      BEQ_I, BNE_I, BLT_I, BGE_I, BLTU_I, BGEU_I: begin
        f.br_redirect = 1;
        f.br_target = taken ? d.PC + d.sxt_imm : d.pcplus;
      end
      default: f = '0;
    endcase
    return f;
  endfunction

  // Present one instruction for a cycle and capture combinational and latched outputs.
  task automatic drive_one(input de_latch_t d);
    din = d;
    @(negedge clk);
    obs_de = to_de;
    obs_fe = to_fe;
    @(posedge clk); #1;
    obs_latch = lat;
    din = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    din = mk(JAL_I, 32'h40, 0, 0, 32'h10, 5'd1, 1'b1);
    @(negedge clk);
    tests++;
    if (to_fe !== '0) begin fails++; $display("[TB] FAIL reset_fe: got %h want 0", to_fe); end
    tests++;
    if (to_de !== '0) begin fails++; $display("[TB] FAIL reset_de: got %h want 0", to_de); end
    @(posedge clk); #1;
    tests++;
    if (lat !== '0) begin fails++; $display("[TB] FAIL reset_latch: got %h want 0", lat); end
    reset = 1'b0;
    din = '0;
  endtask

  task automatic test_alu();
    de_latch_t d;
    d = mk(ADDI_I, 32'h200, 32'hFFFF_FFFF, 32'h5, 32'h1, 5'd7, 1'b1);
    drive_one(d);
    tests++;
    if (obs_latch.result !== 32'h0) begin fails++; $display("[TB] FAIL addi_result: got %h want 0", obs_latch.result); end
    tests++;
    if (obs_latch.rd !== 5'd7 || obs_latch.wr_reg !== 1'b1) begin
      fails++; $display("[TB] FAIL addi_rd_wr: got rd=%0d wr=%b want rd=7 wr=1", obs_latch.rd, obs_latch.wr_reg);
    end
    tests++;
    if (obs_latch !== ref_latch(d)) begin fails++; $display("[TB] FAIL addi_latch: got %h want %h", obs_latch, ref_latch(d)); end
    d = mk(SLTU_I, 32'h204, 32'h1, 32'hFFFF_FFFF, 32'h0, 5'd8, 1'b1);
    drive_one(d);
    tests++;
    if (obs_latch.result !== 32'h1) begin fails++; $display("[TB] FAIL sltu: got %h want 1", obs_latch.result); end
    d = mk(SLT_I, 32'h208, 32'h1, 32'hFFFF_FFFF, 32'h0, 5'd9, 1'b1);
    drive_one(d);
    tests++;
    if (obs_latch.result !== 32'h0) begin fails++; $display("[TB] FAIL slt: got %h want 0", obs_latch.result); end
    tests++;
    if (obs_de.agex_stall !== 1'b0 || obs_de.agex_rd !== 5'd9 || obs_de.agex_wr !== 1'b1) begin
      fails++; $display("[TB] FAIL slt_hazard: got %h want stall=0 rd=9 wr=1", obs_de);
    end
  endtask

  task automatic test_branch();
    de_latch_t d;
    d = mk(BNE_I, 32'h100, 32'h3, 32'h3, 32'h20, 5'd0, 1'b0);
    drive_one(d);
    tests++;
    if (obs_fe.br_redirect !== 1'b1 || obs_fe.br_target !== 32'h104) begin
      fails++; $display("[TB] FAIL bne_not_taken: got %h want redirect=1 target=104", obs_fe);
    end
    tests++;
    if (obs_latch.wr_reg !== 1'b0) begin fails++; $display("[TB] FAIL bne_wr_reg: got %b want 0", obs_latch.wr_reg); end
    d = mk(BNE_I, 32'h100, 32'h3, 32'h4, 32'h20, 5'd0, 1'b0);
    drive_one(d);
    tests++;
    if (obs_fe.br_redirect !== 1'b1 || obs_fe.br_target !== 32'h120) begin
      fails++; $display("[TB] FAIL bne_taken: got %h want redirect=1 target=120", obs_fe);
    end
  endtask

  task automatic test_jalr();
    de_latch_t d;
    d = mk(JALR_I, 32'h44, 32'h203, 32'h0, 32'h2, 5'd1, 1'b1);
    drive_one(d);
    tests++;
    if (obs_fe.br_redirect !== 1'b1 || obs_fe.br_target !== 32'h204) begin
      fails++; $display("[TB] FAIL jalr_target: got %h want redirect=1 target=204", obs_fe);
    end
    tests++;
    if (obs_latch.result !== 32'h48) begin fails++; $display("[TB] FAIL jalr_link: got %h want 48", obs_latch.result); end
  endtask

  task automatic test_mem();
    de_latch_t d;
    d = mk(LW_I, 32'h300, 32'h1000, 32'h0, 32'hFFFF_FFFC, 5'd3, 1'b1);
    drive_one(d);
    tests++;
    if (obs_latch.result !== 32'h0000_0FFC || obs_latch.st_data !== 32'h0) begin
      fails++; $display("[TB] FAIL lw_addr: got res=%h st=%h want res=00000ffc st=0", obs_latch.result, obs_latch.st_data);
    end
    d = mk(SW_I, 32'h304, 32'h1000, 32'hDEAD_BEEF, 32'h8, 5'd0, 1'b0);
    drive_one(d);
    tests++;
    if (obs_latch.st_data !== 32'hDEAD_BEEF || obs_latch.result !== 32'h1008) begin
      fails++; $display("[TB] FAIL sw_data: got res=%h st=%h want res=00001008 st=deadbeef", obs_latch.result, obs_latch.st_data);
    end
    drive_one('0);
    tests++;
    if (obs_latch !== '0 || obs_fe !== '0 || obs_de !== '0) begin
      fails++; $display("[TB] FAIL bubble: got latch=%h fe=%h de=%h want all 0", obs_latch, obs_fe, obs_de);
    end
  endtask

  task automatic test_random_alu();
    de_latch_t d;
    agex_latch_t el;
    to_fe_t ef;
    for (int k = 0; k < 60; k++) begin
      d = mk(op_e'($urandom_range(0, 31)), $urandom & 32'hFFFF_FFFC, pick(), pick(), pick(),
             5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      el = ref_latch(d);
      ef = ref_fe(d);
      drive_one(d);
      tests++;
      if (obs_latch !== el) begin fails++; $display("[TB] FAIL rand_latch op=%s: got %h want %h", d.op_I.name(), obs_latch, el); end
      tests++;
      if (obs_fe !== ef) begin fails++; $display("[TB] FAIL rand_fe op=%s: got %h want %h", d.op_I.name(), obs_fe, ef); end
      tests++;
      if (obs_de.agex_stall !== 1'b0 || obs_de.agex_rd !== el.rd || obs_de.agex_wr !== el.wr_reg) begin
        fails++; $display("[TB] FAIL rand_hazard op=%s: got %h want rd=%0d wr=%b", d.op_I.name(), obs_de, el.rd, el.wr_reg);
      end
    end
  endtask

  // Issue a MUL in the current cycle, hold bubbles, and check every cycle until it lands.
  task automatic do_mul(input de_latch_t d);
    agex_latch_t el;
    el = ref_latch(d);
    din = d;
    @(negedge clk);
    tests++;
    if (to_de.agex_stall !== 1'b1 || to_de.agex_rd !== d.rd || to_de.agex_wr !== d.wr_reg) begin
      fails++; $display("[TB] FAIL mul_issue_hazard: got %h want stall=1 rd=%0d wr=%b", to_de, d.rd, d.wr_reg);
    end
    @(posedge clk); #1;
    din = '0;
    for (int k = 1; k <= N; k++) begin
      tests++;
      if (lat !== '0) begin fails++; $display("[TB] FAIL mul_bubble cycle %0d: got %h want 0", k, lat); end
      @(negedge clk);
      tests++;
      if (to_de.agex_stall !== 1'b1 || to_de.agex_rd !== d.rd) begin
        fails++; $display("[TB] FAIL mul_busy_hazard cycle %0d: got %h want stall=1 rd=%0d", k, to_de, d.rd);
      end
      @(posedge clk); #1;
    end
    tests++;
    if (lat !== el) begin fails++; $display("[TB] FAIL mul_result: got %h want %h", lat, el); end
  endtask

  task automatic test_mul();
    de_latch_t d;
    d = mk(MUL_I, 32'h400, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 5'd12, 1'b1);
    do_mul(d);
    tests++;
    if (lat.result !== 32'h242D_2080) begin fails++; $display("[TB] FAIL mul_const: got %h want 242d2080", lat.result); end
    @(negedge clk);
    tests++;
    if (to_de.agex_stall !== 1'b0) begin fails++; $display("[TB] FAIL mul_stall_release: got %b want 0", to_de.agex_stall); end
    @(posedge clk); #1;
  endtask

  task automatic test_mul_reset();
    de_latch_t d;
    din = mk(MUL_I, 32'h500, $urandom, $urandom, 32'h0, 5'd20, 1'b1);
    @(posedge clk); #1;
    din = '0;
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tests++;
    if (lat !== '0) begin fails++; $display("[TB] FAIL mulrst_latch: got %h want 0", lat); end
    @(negedge clk);
    tests++;
    if (to_de !== '0) begin fails++; $display("[TB] FAIL mulrst_hazard: got %h want 0", to_de); end
    @(posedge clk); #1;
    d = mk(ADD_I, 32'h600, $urandom, $urandom, 32'h0, 5'd4, 1'b1);
    drive_one(d);
    tests++;
    if (obs_latch !== ref_latch(d)) begin fails++; $display("[TB] FAIL mulrst_add: got %h want %h", obs_latch, ref_latch(d)); end
  endtask

  task automatic test_back_to_back();
    de_latch_t d;
    do_mul(mk(MUL_I, 32'h700, $urandom, $urandom, 32'h0, 5'd5, 1'b1));
    do_mul(mk(MUL_I, 32'h704, pick(), pick(), 32'h0, 5'd6, 1'b1));
    d = mk(XOR_I, 32'h708, $urandom, $urandom, 32'h0, 5'd10, 1'b1);
    drive_one(d);
    tests++;
    if (obs_latch !== ref_latch(d) || obs_de.agex_stall !== 1'b0) begin
      fails++; $display("[TB] FAIL b2b_follow: got %h stall=%b want %h stall=0", obs_latch, obs_de.agex_stall, ref_latch(d));
    end
  endtask

  initial begin
    reset = 1'b1;
    din = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_alu();
    test_branch();
    test_jalr();
    test_mem();
    test_random_alu();
    test_mul();
    test_mul_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
